// File: rtl/autosym_sweep_ctrl_pkg.sv
// Shared types and constants for the autosymmetry sweep controller.
// AUTOSYM_EARLY_EXIT_EN is consumed by the top, not here.
package autosym_pkg;

    localparam int N_IN_DEF = 16;
    localparam int MAX_LAT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/autosym_sweep_ctrl_if.sv
// Control, status and FUT stimulus/response bundle of the sweep controller.
// The slave side is the controller; the master side drives start/alpha/FUT.
interface autosym_sweep_ctrl_if
    import autosym_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = cnt_w(N_IN)
);

    logic             start;
    logic             abort;
    logic [N_IN-1:0]  alpha;
    logic [N_IN-1:0]  vec_a;
    logic [N_IN-1:0]  vec_b;
    logic             y_a;
    logic             y_b;
    logic             busy;
    logic             done;
    logic             is_sym;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] onset_cnt;
    logic [N_IN-1:0]  first_fail;

    modport master (
        output start, abort, alpha, y_a, y_b,
        input  vec_a, vec_b, busy, done, is_sym,
        input  mismatch_cnt, onset_cnt, first_fail
    );

    modport slave (
        input  start, abort, alpha, y_a, y_b,
        output vec_a, vec_b, busy, done, is_sym,
        output mismatch_cnt, onset_cnt, first_fail
    );

endinterface

// File: rtl/autosym_sweep_ctrl_tag_pipe.sv
// LAT-deep (valid, x) delay line that tracks which x a FUT response belongs to.
// LAT=0 degenerates to a wire; flush drops every in-flight tag.
module autosym_tag_pipe #(
    parameter int W   = 16,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_x_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_x_o
);

    if (LAT == 0) begin : g_wire
        logic unused_pipe;
        assign unused_pipe = ^{clk, rst_n, flush_i};
        assign out_vld_o   = in_vld_i;
        assign out_x_o     = in_x_i;
    end else begin : g_reg
        logic [LAT-1:0] vld_q;
        logic [W-1:0]   x_q [LAT];

        // shift tags one stage per cycle; flush kills all valids
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < LAT; i++) begin
                    x_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= in_vld_i & ~flush_i;
                x_q[0]   <= in_x_i;
                for (int i = 1; i < LAT; i++) begin
                    vld_q[i] <= vld_q[i-1] & ~flush_i;
                    x_q[i]   <= x_q[i-1];
                end
            end
        end

        assign out_vld_o = vld_q[LAT-1];
        assign out_x_o   = x_q[LAT-1];
    end

endmodule

// File: rtl/autosym_sweep_ctrl.sv
// Sweeps every x through FUT copies A(x) and B(x^alpha) and tallies results.
// Define AUTOSYM_EARLY_EXIT_EN to stop the sweep at the first mismatch.
module autosym_sweep_ctrl
    import autosym_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int LAT   = 0,
    parameter int CNT_W = cnt_w(N_IN)
) (
    input logic                 clk,
    input logic                 rst_n,
    autosym_sweep_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SWEEP = ST_SWEEP;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    localparam int DW = $clog2(MAX_LAT + 1);
    localparam logic [DW-1:0] DRN_LAST =
        (LAT > 0) ? DW'(LAT - 1) : '0;

`ifdef AUTOSYM_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  x_q, x_d;
    logic [N_IN-1:0]  alpha_q, alpha_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [CNT_W-1:0] onset_q, onset_d;
    logic [N_IN-1:0]  ffail_q, ffail_d;
    logic             is_sym_q, is_sym_d;
    logic             done_q, done_d;

    logic             iss_vld;
    logic             rsp_vld;
    logic [N_IN-1:0]  rsp_x;
    logic             flush;
    logic             miss;
    logic             first;
    logic             stop;
    logic             finish;
    logic             abort_hit;

    assign iss_vld = (state_q == S_SWEEP);

    autosym_tag_pipe #(
        .W   (N_IN),
        .LAT (LAT)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .in_vld_i  (iss_vld),
        .in_x_i    (x_q),
        .out_vld_o (rsp_vld),
        .out_x_o   (rsp_x)
    );

    // next-state: sequencing, response tally and result latching
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        alpha_d  = alpha_q;
        drn_d    = drn_q;
        mism_d   = mism_q;
        onset_d  = onset_q;
        ffail_d  = ffail_q;
        is_sym_d = is_sym_q;
        done_d   = 1'b0;
        flush    = 1'b0;
        finish   = 1'b0;

        miss      = rsp_vld && (bus.y_a != bus.y_b);
        first     = miss && (mism_q == '0);
        stop      = EARLY && first;
        abort_hit = bus.abort && (state_q != S_IDLE);

        if (rsp_vld) begin
            onset_d = onset_q + CNT_W'(bus.y_a);
            if (miss) begin
                mism_d = mism_q + CNT_W'(1);
            end
            if (first) begin
                ffail_d = rsp_x;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    alpha_d  = bus.alpha;
                    x_d      = '0;
                    drn_d    = '0;
                    mism_d   = '0;
                    onset_d  = '0;
                    ffail_d  = '0;
                    is_sym_d = 1'b0;
                    state_d  = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (stop || (x_q == '1)) begin
                    flush = stop;
                    if (LAT == 0) begin
                        finish = 1'b1;
                    end else begin
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end
                end else begin
                    x_d = x_q + N_IN'(1);
                end
            end
            S_DRAIN: begin
                flush = stop;
                if (drn_q == DRN_LAST) begin
                    finish = 1'b1;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            is_sym_d = (mism_d == '0);
        end

        if (abort_hit) begin
            state_d  = S_IDLE;
            flush    = 1'b1;
            done_d   = 1'b0;
            is_sym_d = 1'b0;
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            alpha_q  <= '0;
            drn_q    <= '0;
            mism_q   <= '0;
            onset_q  <= '0;
            ffail_q  <= '0;
            is_sym_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            alpha_q  <= alpha_d;
            drn_q    <= drn_d;
            mism_q   <= mism_d;
            onset_q  <= onset_d;
            ffail_q  <= ffail_d;
            is_sym_q <= is_sym_d;
            done_q   <= done_d;
        end
    end

    assign bus.vec_a        = x_q;
    assign bus.vec_b        = x_q ^ alpha_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.is_sym       = is_sym_q;
    assign bus.mismatch_cnt = mism_q;
    assign bus.onset_cnt    = onset_q;
    assign bus.first_fail   = ffail_q;

endmodule

// File: tb/tb_autosym_sweep_ctrl.sv
// Scoreboard bench: four controllers (LAT 0/3, alpha 1/8) sweep in parallel.
// Expected results for AUTOSYM_EARLY_EXIT_EN builds are selected by the macro.
module tb_autosym_sweep_ctrl;

    typedef struct {
        bit sym;
        int mism;
        int ons;
        int ff;
        int blo;
        int bhi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   bc [4];
    exp_t q [4][$];

    always #5 clk = ~clk;

    autosym_sweep_ctrl_if #(.N_IN(16), .CNT_W(17)) b0 ();
    autosym_sweep_ctrl_if #(.N_IN(16), .CNT_W(17)) b1 ();
    autosym_sweep_ctrl_if #(.N_IN(16), .CNT_W(17)) b2 ();
    autosym_sweep_ctrl_if #(.N_IN(16), .CNT_W(17)) b3 ();

    autosym_sweep_ctrl #(.N_IN(16), .LAT(0), .CNT_W(17)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    autosym_sweep_ctrl #(.N_IN(16), .LAT(0), .CNT_W(17)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    autosym_sweep_ctrl #(.N_IN(16), .LAT(3), .CNT_W(17)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));
    autosym_sweep_ctrl #(.N_IN(16), .LAT(3), .CNT_W(17)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic logic fut(input logic [15:0] x);
        return x[3] & x[4];
    endfunction

    // FUT copies: combinational for LAT=0, three register stages for LAT=3
    logic [2:0] p2a, p2b, p3a, p3b;
    assign b0.y_a = fut(b0.vec_a);
    assign b0.y_b = fut(b0.vec_b);
    assign b1.y_a = fut(b1.vec_a);
    assign b1.y_b = fut(b1.vec_b);
    always @(posedge clk) begin
        p2a <= {p2a[1:0], fut(b2.vec_a)};
        p2b <= {p2b[1:0], fut(b2.vec_b)};
        p3a <= {p3a[1:0], fut(b3.vec_a)};
        p3b <= {p3b[1:0], fut(b3.vec_b)};
    end
    assign b2.y_a = p2a[2];
    assign b2.y_b = p2b[2];
    assign b3.y_a = p3a[2];
    assign b3.y_b = p3b[2];

    function automatic exp_t mk(bit s, int m, int o, int f, int lo, int hi);
        exp_t e;
        e.sym = s; e.mism = m; e.ons = o; e.ff = f; e.blo = lo; e.bhi = hi;
        return e;
    endfunction

    function automatic void chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endfunction

    function automatic void mon(int id, bit s, int m, int o, int f);
        exp_t e;
        if (q[id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_done: got done expected none", id);
            bc[id] = 0;
            return;
        end
        e = q[id].pop_front();
        chk($sformatf("dut%0d is_sym", id), int'(s), int'(e.sym));
        chk($sformatf("dut%0d mismatch_cnt", id), m, e.mism);
        chk($sformatf("dut%0d onset_cnt", id), o, e.ons);
        chk($sformatf("dut%0d first_fail", id), f, e.ff);
        checks++;
        if (bc[id] < e.blo || bc[id] > e.bhi) begin
            errors++;
            $display("FAIL dut%0d busy_cycles: got %0d expected %0d..%0d",
                     id, bc[id], e.blo, e.bhi);
        end
        bc[id] = 0;
    endfunction

    // monitor: count busy cycles and score every done pulse
    always @(negedge clk) begin
        if (b0.busy) bc[0]++;
        if (b1.busy) bc[1]++;
        if (b2.busy) bc[2]++;
        if (b3.busy) bc[3]++;
        if (b0.done) mon(0, b0.is_sym, int'(b0.mismatch_cnt),
                         int'(b0.onset_cnt), int'(b0.first_fail));
        if (b1.done) mon(1, b1.is_sym, int'(b1.mismatch_cnt),
                         int'(b1.onset_cnt), int'(b1.first_fail));
        if (b2.done) mon(2, b2.is_sym, int'(b2.mismatch_cnt),
                         int'(b2.onset_cnt), int'(b2.first_fail));
        if (b3.done) mon(3, b3.is_sym, int'(b3.mismatch_cnt),
                         int'(b3.onset_cnt), int'(b3.first_fail));
    end

    task automatic chk_zero(string tag);
        chk({tag, " busy"}, int'(b0.busy), 0);
        chk({tag, " done"}, int'(b0.done), 0);
        chk({tag, " is_sym"}, int'(b0.is_sym), 0);
        chk({tag, " vec_a"}, int'(b0.vec_a), 0);
        chk({tag, " vec_b"}, int'(b0.vec_b), 0);
        chk({tag, " mismatch_cnt"}, int'(b0.mismatch_cnt), 0);
        chk({tag, " onset_cnt"}, int'(b0.onset_cnt), 0);
        chk({tag, " first_fail"}, int'(b0.first_fail), 0);
    endtask

    initial begin : stim
        int n;
        b0.start = 0; b0.abort = 0; b0.alpha = '0;
        b1.start = 0; b1.abort = 0; b1.alpha = '0;
        b2.start = 0; b2.abort = 0; b2.alpha = '0;
        b3.start = 0; b3.abort = 0; b3.alpha = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        b0.alpha = 16'h0001;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("midsweep busy", int'(b0.busy), 1);
        chk("midsweep vec_a", int'(b0.vec_a), 40);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bc = '{default: 0};

        // four concurrent full sweeps
        @(negedge clk);
        b0.alpha = 16'h0001; b1.alpha = 16'h0008;
        b2.alpha = 16'h0001; b3.alpha = 16'h0008;
        b0.start = 1; b1.start = 1; b2.start = 1; b3.start = 1;
        q[0].push_back(mk(1, 0, 16384, 0, 65536, 65536));
        q[2].push_back(mk(1, 0, 16384, 0, 65539, 65539));
`ifdef AUTOSYM_EARLY_EXIT_EN
        q[1].push_back(mk(0, 1, 0, 16, 1, 31));
        q[3].push_back(mk(0, 1, 0, 16, 1, 31));
`else
        q[1].push_back(mk(0, 32768, 16384, 16, 65536, 65536));
        q[3].push_back(mk(0, 32768, 16384, 16, 65539, 65539));
`endif
        @(negedge clk);
        b0.start = 0; b1.start = 0; b2.start = 0; b3.start = 0;

        // start while busy must be ignored, new alpha included
        n = 0;
        while (b0.vec_a != 16'd50 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_x50 vec_a", int'(b0.vec_a), 50);
        b0.alpha = 16'hFFFF;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        b0.alpha = 16'h0001;

        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0
               && n < 70000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d pending_done", i), q[i].size(), 0);
            q[i].delete();
        end

        // abort at x=100: no done, is_sym cleared, partial counts kept
        @(negedge clk);
        b0.alpha = 16'h0001;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        n = 0;
        while (b0.vec_a != 16'd100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_x100 vec_a", int'(b0.vec_a), 100);
        b0.abort = 1'b1;
        @(negedge clk);
        b0.abort = 1'b0;
        chk("abort busy", int'(b0.busy), 0);
        chk("abort is_sym", int'(b0.is_sym), 0);
        chk("abort mismatch_cnt", int'(b0.mismatch_cnt), 0);
        chk("abort onset_cnt", int'(b0.onset_cnt), 24);

        // abort and start together in IDLE: start loses
        b0.start = 1'b1;
        b0.abort = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        b0.abort = 1'b0;
        chk("abort_start busy", int'(b0.busy), 0);
        chk("abort_start onset_cnt", int'(b0.onset_cnt), 24);
        repeat (10) @(negedge clk);
        chk("idle busy", int'(b0.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
